// File: rtl/ioctl_loader_fifo.sv
// Buffered bridge from the HPS ioctl download stream to the PC88 loader port.
// Define IOCTL_LDR_CHECKSUM_EN to keep a running 16-bit sum of delivered bytes on ldr_sum.
module ioctl_loader_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 19
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic [AW-1:0] ldr_adr,
    output logic [7:0]    ldr_wdat,
    output logic          ldr_wr,
    input  logic          ldr_ack,
    output logic          ldr_oe,
    output logic          ldr_done,
    output logic          ldr_ovf,
    output logic [15:0]   ldr_sum
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = AW + 8;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          act_q, act_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          dl_q;
    logic          ack_q;

    logic full, empty, dl_rise, ack_rise, push, pop, start_req, done_set;

    assign full      = (count_q == FullCnt);
    assign empty     = (count_q == '0);
    assign dl_rise   = ioctl_download & ~dl_q;
    assign ack_rise  = ldr_ack & ~ack_q;
    assign push      = ioctl_wr & act_q & ~full;
    // A restart takes priority over any in-flight handshake.
    assign pop       = (state_q == StReq) & ack_rise & ~dl_rise;
    assign start_req = (state_q == StIdle) & ~empty & ~dl_rise;
    assign done_set  = act_q & ~ioctl_download & empty & (state_q == StIdle);

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (dl_rise) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Drain FSM: head is latched on entry to StReq and held until the ack edge.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    state_d         = StReq;
                    {adr_d, wdat_d} = mem_q[rptr_q];
                end
            end
            StReq: begin
                if (dl_rise || ack_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        act_d  = act_q;
        done_d = done_q;
        ovf_d  = ovf_q;
        if (dl_rise) begin
            act_d  = 1'b1;
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end else begin
            if (done_set) begin
                done_d = 1'b1;
                act_d  = 1'b0;
            end
            if (ioctl_wr && act_q && full) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= StIdle;
            adr_q   <= '0;
            wdat_q  <= '0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dl_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            act_q   <= act_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            dl_q    <= ioctl_download;
            ack_q   <= ldr_ack;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wptr_q] <= {ioctl_addr, ioctl_dout};
    end

`ifdef IOCTL_LDR_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (dl_rise)  sum_d = '0;
        else if (pop) sum_d = sum_q + {8'h00, wdat_q};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign ldr_sum = sum_q;
`else
    assign ldr_sum = 16'h0000;
`endif

    assign ioctl_wait = full;
    assign ldr_adr    = adr_q;
    assign ldr_wdat   = wdat_q;
    assign ldr_wr     = (state_q == StReq);
    assign ldr_oe     = act_q;
    assign ldr_done   = done_q;
    assign ldr_ovf    = ovf_q;

endmodule

// File: tb/tb_ioctl_loader_fifo.sv
// Self-checking bench for ioctl_loader_fifo: random bytes against a queue-based delivery model.
module tb_ioctl_loader_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = 19;

    logic          clk_sys        = 1'b0;
    logic          reset          = 1'b1;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr       = 1'b0;
    logic [AW-1:0] ioctl_addr     = '0;
    logic [7:0]    ioctl_dout     = '0;
    logic          ldr_ack        = 1'b0;
    logic          ioctl_wait;
    logic [AW-1:0] ldr_adr;
    logic [7:0]    ldr_wdat;
    logic          ldr_wr;
    logic          ldr_oe;
    logic          ldr_done;
    logic          ldr_ovf;
    logic [15:0]   ldr_sum;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [AW+7:0] q[$];
    logic [15:0]   sum_m = '0;

    ioctl_loader_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ldr_adr        (ldr_adr),
        .ldr_wdat       (ldr_wdat),
        .ldr_wr         (ldr_wr),
        .ldr_ack        (ldr_ack),
        .ldr_oe         (ldr_oe),
        .ldr_done       (ldr_done),
        .ldr_ovf        (ldr_ovf),
        .ldr_sum        (ldr_sum)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_sum();
`ifdef IOCTL_LDR_CHECKSUM_EN
        return sum_m;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wait"}, 32'(ioctl_wait), 0);
        check({tag, "_adr"},  32'(ldr_adr),    0);
        check({tag, "_wdat"}, 32'(ldr_wdat),   0);
        check({tag, "_wr"},   32'(ldr_wr),     0);
        check({tag, "_oe"},   32'(ldr_oe),     0);
        check({tag, "_done"}, 32'(ldr_done),   0);
        check({tag, "_ovf"},  32'(ldr_ovf),    0);
        check({tag, "_sum"},  32'(ldr_sum),    0);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    // Honours ioctl_wait; random data avoids 0x55, reserved for the dropped byte.
    task automatic push_rand();
        int            guard = 0;
        logic [AW-1:0] a;
        logic [7:0]    d;
        while (ioctl_wait && guard < 100) begin
            tick();
            guard++;
        end
        check("wait_released", 32'(ioctl_wait), 0);
        a = AW'($urandom);
        d = 8'($urandom);
        if (d == 8'h55) d = 8'h56;
        q.push_back({a, d});
        push(a, d);
    endtask

    task automatic start_download();
        ioctl_download = 1'b1;
        sum_m          = '0;
        tick();
        check("restart_done", 32'(ldr_done), 0);
        check("restart_ovf",  32'(ldr_ovf),  0);
        check("restart_sum",  32'(ldr_sum),  32'(exp_sum()));
        check("restart_oe",   32'(ldr_oe),   1);
    endtask

    // Wait for a request, compare with the model head, hold a random time, then ack.
    task automatic deliver_one();
        int            guard = 0;
        int            k;
        logic [AW+7:0] e;
        while (!ldr_wr && guard < 50) begin
            tick();
            guard++;
        end
        check("ldr_wr_seen", 32'(ldr_wr), 1);
        e = (q.size() != 0) ? q.pop_front() : '1;
        check("ldr_adr",  32'(ldr_adr),  32'(e[AW+7:8]));
        check("ldr_wdat", 32'(ldr_wdat), 32'(e[7:0]));
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) begin
            tick();
            check("wr_hold",     32'(ldr_wr),   1);
            check("adr_stable",  32'(ldr_adr),  32'(e[AW+7:8]));
            check("wdat_stable", 32'(ldr_wdat), 32'(e[7:0]));
        end
        sum_m   = sum_m + {8'h00, e[7:0]};
        ldr_ack = 1'b1;
        tick();
        ldr_ack = 1'b0;
        check("wr_drop_on_ack", 32'(ldr_wr), 0);
    endtask

    initial begin
        // Reset state
        #12;
        check_reset_vals("reset");
        tick();
        reset = 1'b0;
        tick();

        // Single byte with exact latency
        start_download();
        push(19'h00010, 8'hA5);
        check("latency_n", 32'(ldr_wr), 0);
        tick();
        check("latency_n1", 32'(ldr_wr),   1);
        check("single_adr", 32'(ldr_adr),  32'h10);
        check("single_wdat", 32'(ldr_wdat), 32'hA5);
        tick();
        tick();
        check("single_hold", 32'(ldr_wr), 1);
        ldr_ack = 1'b1;
        tick();
        ldr_ack = 1'b0;
        check("single_ack_drop", 32'(ldr_wr), 0);
        sum_m = sum_m + 16'h00A5;
        ioctl_download = 1'b0;
        tick();
        tick();
        check("single_done", 32'(ldr_done), 1);
        check("single_oe",   32'(ldr_oe),   0);
        check("single_sum",  32'(ldr_sum),  32'(exp_sum()));

        // Fill and stall: 6 bytes, ack withheld 20 cycles
        start_download();
        for (int i = 0; i < DEPTH - 1; i++) push_rand();
        check("wait_below_full", 32'(ioctl_wait), 0);
        push_rand();
        check("wait_full", 32'(ioctl_wait), 1);
        repeat (20) tick();
        check("stall_wait", 32'(ioctl_wait), 1);
        check("stall_wr",   32'(ldr_wr),     1);
        deliver_one();
        check("wait_after_pop", 32'(ioctl_wait), 0);
        push_rand();
        deliver_one();
        push_rand();
        for (int i = 0; i < DEPTH; i++) deliver_one();
        check("fill_model_empty", 32'(q.size()), 0);
        check("fill_no_ovf",      32'(ldr_ovf),  0);
        check("fill_sum",         32'(ldr_sum),  32'(exp_sum()));
        ioctl_download = 1'b0;
        tick();
        tick();
        check("fill_done", 32'(ldr_done), 1);

        // Overflow: forced write while full is dropped
        start_download();
        for (int i = 0; i < DEPTH; i++) push_rand();
        check("ovf_full", 32'(ioctl_wait), 1);
        push(AW'($urandom), 8'h55);
        check("ovf_set",       32'(ldr_ovf),    1);
        check("ovf_still_full", 32'(ioctl_wait), 1);
        for (int i = 0; i < DEPTH; i++) deliver_one();
        repeat (5) tick();
        check("ovf_no_extra_wr", 32'(ldr_wr), 0);
        check("ovf_sum",         32'(ldr_sum), 32'(exp_sum()));

        // Late drain: download falls with 3 bytes queued
        for (int i = 0; i < 3; i++) push_rand();
        ioctl_download = 1'b0;
        for (int i = 0; i < 3; i++) begin
            deliver_one();
            check("late_done_low", 32'(ldr_done), 0);
        end
        tick();
        check("late_done_set", 32'(ldr_done), 1);
        check("late_oe",       32'(ldr_oe),   0);
        check("late_ovf_sticky", 32'(ldr_ovf), 1);
        check("late_sum",      32'(ldr_sum),  32'(exp_sum()));

        // Restart clears flags; stray ack in idle must not pop
        start_download();
        ldr_ack = 1'b1;
        tick();
        ldr_ack = 1'b0;
        tick();
        tick();
        check("stray_ack_no_wr",   32'(ldr_wr),     0);
        check("stray_ack_no_wait", 32'(ioctl_wait), 0);
        push_rand();
        deliver_one();
        check("stray_sum", 32'(ldr_sum), 32'(exp_sum()));

        // Reset mid-transfer with bytes queued
        for (int i = 0; i < 3; i++) push_rand();
        check("pre_reset_wr", 32'(ldr_wr), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        q.delete();
        ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset_no_wr", 32'(ldr_wr), 0);
            check("post_reset_no_oe", 32'(ldr_oe), 0);
        end
        start_download();
        push_rand();
        deliver_one();
        ioctl_download = 1'b0;
        tick();
        tick();
        check("final_done", 32'(ldr_done), 1);
        check("final_sum",  32'(ldr_sum),  32'(exp_sum()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
